// File: rtl/change_sequencer_if.sv
// Request and coin-mechanism signals of change_sequencer, bundled for the credit logic (master)
// and the sequencer itself (slave).
interface change_sequencer_if #(
    parameter int INV_W = 8
);
    logic             start;
    logic [8:0]       change;
    logic             load_inv;
    logic [INV_W-1:0] inv_q;
    logic [INV_W-1:0] inv_d;
    logic [INV_W-1:0] inv_n;
    logic             coin_ack;
    logic             eject_q;
    logic             eject_d;
    logic             eject_n;
    logic             busy;
    logic             done;
    logic             err;
    logic [8:0]       remaining;
    logic [INV_W-1:0] cnt_q;
    logic [INV_W-1:0] cnt_d;
    logic [INV_W-1:0] cnt_n;

    modport master (
        output start, change, load_inv, inv_q, inv_d, inv_n, coin_ack,
        input  eject_q, eject_d, eject_n, busy, done, err, remaining, cnt_q, cnt_d, cnt_n
    );

    modport slave (
        input  start, change, load_inv, inv_q, inv_d, inv_n, coin_ack,
        output eject_q, eject_d, eject_n, busy, done, err, remaining, cnt_q, cnt_d, cnt_n
    );
endinterface

// File: rtl/change_sequencer.sv
// Greedy change dispenser: ejects quarters, dimes and nickels one at a time from its own
// inventory, waiting for the mechanism's acknowledge after each pulse.
module change_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int INV_W        = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    change_sequencer_if.slave bus
);

    localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_FINISH
    } SeqState;

    typedef enum logic [1:0] {
        COIN_Q,
        COIN_D,
        COIN_N
    } CoinSel;

    SeqState          r_state;
    SeqState          w_nextState;
    CoinSel           r_coin;
    CoinSel           w_pick;
    logic [8:0]       r_remaining;
    logic [INV_W-1:0] r_cntQ;
    logic [INV_W-1:0] r_cntD;
    logic [INV_W-1:0] r_cntN;
    logic             r_err;
    logic [PW-1:0]    r_pulseCnt;
    logic [TW-1:0]    r_waitCnt;

    logic             w_loadInv;
    logic             w_accept;
    logic             w_pickValid;
    logic             w_setErr;
    logic             w_takeCoin;
    logic             w_ejectQ;
    logic             w_ejectD;
    logic             w_ejectN;
    logic             w_busy;
    logic             w_done;
    logic [8:0]       w_coinValue;

    always_comb begin
        case (r_coin)
            COIN_Q:  w_coinValue = 9'd25;
            COIN_D:  w_coinValue = 9'd10;
            default: w_coinValue = 9'd5;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Ejects decode straight from state so an asynchronous reset drops them at once.
    always_comb begin
        w_nextState = r_state;
        w_loadInv   = 1'b0;
        w_accept    = 1'b0;
        w_pickValid = 1'b0;
        w_pick      = COIN_Q;
        w_setErr    = 1'b0;
        w_takeCoin  = 1'b0;
        w_ejectQ    = 1'b0;
        w_ejectD    = 1'b0;
        w_ejectN    = 1'b0;
        w_busy      = (r_state != ST_IDLE);
        w_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.load_inv) begin
                    w_loadInv = 1'b1;
                end else if (bus.start) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (r_remaining < 9'd5) begin
                    w_setErr    = (r_remaining != 9'd0);
                    w_nextState = ST_FINISH;
                end else if (r_remaining >= 9'd25 && r_cntQ != '0) begin
                    w_pickValid = 1'b1;
                    w_pick      = COIN_Q;
                    w_nextState = ST_EJECT;
                end else if (r_remaining >= 9'd10 && r_cntD != '0) begin
                    w_pickValid = 1'b1;
                    w_pick      = COIN_D;
                    w_nextState = ST_EJECT;
                end else if (r_cntN != '0) begin
                    w_pickValid = 1'b1;
                    w_pick      = COIN_N;
                    w_nextState = ST_EJECT;
                end else begin
                    w_setErr    = 1'b1;
                    w_nextState = ST_FINISH;
                end
            end
            ST_EJECT: begin
                w_ejectQ = (r_coin == COIN_Q);
                w_ejectD = (r_coin == COIN_D);
                w_ejectN = (r_coin == COIN_N);
                if (r_pulseCnt == PULSE_LAST) begin
                    w_nextState = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.coin_ack) begin
                    w_takeCoin  = 1'b1;
                    w_nextState = ST_SELECT;
                end else if (r_waitCnt == WAIT_LAST) begin
                    w_setErr    = 1'b1;
                    w_nextState = ST_FINISH;
                end
            end
            ST_FINISH: begin
                w_done      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_remaining <= '0;
            r_cntQ      <= '0;
            r_cntD      <= '0;
            r_cntN      <= '0;
            r_err       <= 1'b0;
            r_coin      <= COIN_Q;
            r_pulseCnt  <= '0;
            r_waitCnt   <= '0;
        end else begin
            if (w_loadInv) begin
                r_cntQ <= bus.inv_q;
                r_cntD <= bus.inv_d;
                r_cntN <= bus.inv_n;
            end else if (w_takeCoin) begin
                case (r_coin)
                    COIN_Q:  r_cntQ <= r_cntQ - INV_W'(1);
                    COIN_D:  r_cntD <= r_cntD - INV_W'(1);
                    default: r_cntN <= r_cntN - INV_W'(1);
                endcase
            end

            if (w_accept) begin
                r_remaining <= bus.change;
                r_err       <= 1'b0;
            end else if (w_takeCoin) begin
                r_remaining <= r_remaining - w_coinValue;
            end

            if (w_setErr) begin
                r_err <= 1'b1;
            end

            if (w_pickValid) begin
                r_coin <= w_pick;
            end

            // Both counters restart on entry because SELECT/EJECT always precede their states.
            r_pulseCnt <= (r_state == ST_EJECT) ? r_pulseCnt + PW'(1) : '0;
            r_waitCnt  <= (r_state == ST_WAIT_ACK) ? r_waitCnt + TW'(1) : '0;
        end
    end

    assign bus.eject_q   = w_ejectQ;
    assign bus.eject_d   = w_ejectD;
    assign bus.eject_n   = w_ejectN;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.err       = r_err;
    assign bus.remaining = r_remaining;
    assign bus.cnt_q     = r_cntQ;
    assign bus.cnt_d     = r_cntD;
    assign bus.cnt_n     = r_cntN;

endmodule

// File: tb/tb_change_sequencer.sv
// Self-checking bench for change_sequencer: directed vector table, hand-written corner
// sequences, and randomized transactions against an arithmetic greedy model.
module tb_change_sequencer;

    localparam int P = 4;
    localparam int T = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checkCount = 0;
    int   passCount  = 0;

    change_sequencer_if #(.INV_W(8)) bus ();

    change_sequencer #(
        .PULSE_CYCLES(P),
        .INV_W(8),
        .TIMEOUT(T)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    q;
        int    d;
        int    n;
        int    ch;
        int    mode;
        string coins;
        int    err;
        int    rem;
        int    fq;
        int    fd;
        int    fn;
        int    doneRel;
    } VecT;

    VecT vecs[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkString(input string name, input string actual, input string expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input int change, input logic load,
                                 input int q, input int d, input int n);
        bus.start    = start;
        bus.change   = 9'(change);
        bus.load_inv = load;
        bus.inv_q    = 8'(q);
        bus.inv_d    = 8'(d);
        bus.inv_n    = 8'(n);
    endtask

    task automatic addVec(input int q, input int d, input int n, input int ch, input int mode,
                          input string coins, input int err, input int rem,
                          input int fq, input int fd, input int fn, input int doneRel);
        VecT v;
        v.q = q; v.d = d; v.n = n; v.ch = ch; v.mode = mode;
        v.coins = coins; v.err = err; v.rem = rem;
        v.fq = fq; v.fd = fd; v.fn = fn; v.doneRel = doneRel;
        vecs.push_back(v);
    endtask

    // Greedy with fallback reduces to taking as many of each coin as fit, largest first.
    task automatic refModel(input int q, input int d, input int n, input int ch,
                            output string coins, output int err, output int rem,
                            output int fq, output int fd, output int fn);
        int nq;
        int nd;
        int nn;
        rem = ch;
        nq  = (rem / 25 < q) ? rem / 25 : q;
        rem = rem - 25 * nq;
        nd  = (rem / 10 < d) ? rem / 10 : d;
        rem = rem - 10 * nd;
        nn  = (rem / 5 < n) ? rem / 5 : n;
        rem = rem - 5 * nn;
        coins = "";
        for (int i = 0; i < nq; i++) coins = {coins, "Q"};
        for (int i = 0; i < nd; i++) coins = {coins, "D"};
        for (int i = 0; i < nn; i++) coins = {coins, "N"};
        err = (rem != 0) ? 1 : 0;
        fq  = q - nq;
        fd  = d - nd;
        fn  = n - nn;
    endtask

    // mode 0: coin_ack tied high; 1: ack after a random 1..4 cycle delay; 2: never acked.
    // expDoneRel < 0 means the done cycle is derived from the ack delays actually used.
    task automatic runTxn(input int q, input int d, input int n, input int ch, input int mode,
                          input string expCoins, input int expErr, input int expRem,
                          input int expQ, input int expD, input int expN,
                          input int expDoneRel, input string tag);
        string coins;
        string letter;
        int    c0;
        int    rel;
        int    nHigh;
        int    onehotBad;
        int    widthBad;
        int    width;
        int    inPulse;
        int    inWait;
        int    waitJ;
        int    k;
        int    sumRel;
        int    doneRel;
        int    gotErr;
        int    gotRem;
        int    gotQ;
        int    gotD;
        int    gotN;
        bit    finished;

        @(negedge clk);
        bus.coin_ack = (mode == 0);
        applyStimulus(1'b0, 0, 1'b1, q, d, n);
        @(negedge clk);
        checkOutput({tag, ".loadQ"}, bus.cnt_q, q);
        checkOutput({tag, ".loadN"}, bus.cnt_n, n);
        applyStimulus(1'b1, ch, 1'b0, 0, 0, 0);
        c0 = cyc;
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
        checkOutput({tag, ".busyRise"}, bus.busy, 1);
        checkOutput({tag, ".errClear"}, bus.err, 0);
        checkOutput({tag, ".remLoad"}, bus.remaining, ch);

        coins = ""; onehotBad = 0; widthBad = 0; width = 0;
        inPulse = 0; inWait = 0; waitJ = 0; k = 1; sumRel = 2;
        doneRel = 0; gotErr = 0; gotRem = 0; gotQ = 0; gotD = 0; gotN = 0;
        finished = 1'b0;
        for (int t = 0; t < 3000 && !finished; t++) begin
            if (t > 0) @(negedge clk);
            rel = cyc - c0;
            nHigh = int'(bus.eject_q) + int'(bus.eject_d) + int'(bus.eject_n);
            if (nHigh > 1) onehotBad++;
            if (nHigh != 0) begin
                if (inPulse == 0) begin
                    letter = bus.eject_q ? "Q" : (bus.eject_d ? "D" : "N");
                    coins = {coins, letter};
                    width = 0;
                    inPulse = 1;
                    inWait = 0;
                end
                width++;
                if (mode != 0) bus.coin_ack = 1'b0;
            end else begin
                if (inPulse != 0) begin
                    inPulse = 0;
                    if (width != P) widthBad++;
                    waitJ = 0;
                    k = (mode == 1) ? int'($urandom_range(1, 4)) : 1;
                    sumRel += P + 1 + k;
                    inWait = 1;
                end
                if (inWait != 0) begin
                    waitJ++;
                    if (mode == 1) bus.coin_ack = (waitJ == k);
                end
            end
            if (bus.done) begin
                finished = 1'b1;
                doneRel  = rel;
                gotErr   = bus.err;
                gotRem   = bus.remaining;
                gotQ     = bus.cnt_q;
                gotD     = bus.cnt_d;
                gotN     = bus.cnt_n;
            end
        end

        if (!finished) begin
            checkOutput({tag, ".doneSeen"}, 0, 1);
        end else begin
            checkString({tag, ".coins"}, coins, expCoins);
            checkOutput({tag, ".onehotViolations"}, onehotBad, 0);
            checkOutput({tag, ".badPulseWidths"}, widthBad, 0);
            checkOutput({tag, ".doneCycle"}, doneRel, (expDoneRel < 0) ? sumRel : expDoneRel);
            checkOutput({tag, ".err"}, gotErr, expErr);
            checkOutput({tag, ".remaining"}, gotRem, expRem);
            checkOutput({tag, ".cntQ"}, gotQ, expQ);
            checkOutput({tag, ".cntD"}, gotD, expD);
            checkOutput({tag, ".cntN"}, gotN, expN);
            @(negedge clk);
            checkOutput({tag, ".busyFall"}, bus.busy, 0);
            checkOutput({tag, ".donePulse"}, bus.done, 0);
            checkOutput({tag, ".errSticky"}, bus.err, expErr);
        end
        bus.coin_ack = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        string rCoins;
        int    rErr;
        int    rRem;
        int    rq;
        int    rd;
        int    rn;
        int    q;
        int    d;
        int    n;
        int    ch;
        int    doneCount;
        bit    seen;

        bus.coin_ack = 1'b0;
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", bus.busy, 0);
        checkOutput("reset.done", bus.done, 0);
        checkOutput("reset.err", bus.err, 0);
        checkOutput("reset.remaining", bus.remaining, 0);
        checkOutput("reset.ejects", int'(bus.eject_q) + int'(bus.eject_d) + int'(bus.eject_n), 0);
        checkOutput("reset.cntQ", bus.cnt_q, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postReset.busy", bus.busy, 0);

        addVec(5, 5, 5, 65, 0, "QQDN", 0, 0, 3, 4, 4, 26);
        addVec(0, 5, 5, 30, 0, "DDD", 0, 0, 0, 2, 5, 20);
        addVec(1, 3, 0, 30, 0, "Q", 1, 5, 0, 3, 0, 8);
        addVec(255, 255, 255, 7, 0, "N", 1, 2, 255, 255, 254, 8);
        addVec(5, 5, 5, 25, 2, "Q", 1, 25, 5, 5, 5, P + T + 2);
        addVec(3, 3, 3, 0, 0, "", 0, 0, 3, 3, 3, 2);
        addVec(3, 3, 3, 4, 0, "", 1, 4, 3, 3, 3, 2);
        addVec(0, 0, 0, 10, 0, "", 1, 10, 0, 0, 0, 2);
        addVec(255, 255, 255, 511, 0, "QQQQQQQQQQQQQQQQQQQQD", 1, 1, 235, 254, 255, 128);
        addVec(2, 1, 4, 60, 1, "QQD", 0, 0, 0, 0, 4, -1);

        foreach (vecs[i]) begin
            runTxn(vecs[i].q, vecs[i].d, vecs[i].n, vecs[i].ch, vecs[i].mode, vecs[i].coins,
                   vecs[i].err, vecs[i].rem, vecs[i].fq, vecs[i].fd, vecs[i].fn,
                   vecs[i].doneRel, $sformatf("vec%0d", i));
        end

        // start and load_inv arriving mid-transaction must be ignored.
        @(negedge clk);
        bus.coin_ack = 1'b1;
        applyStimulus(1'b0, 0, 1'b1, 4, 4, 4);
        @(negedge clk);
        applyStimulus(1'b1, 25, 1'b0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
        @(negedge clk);
        checkOutput("busySeq.ejectQ", bus.eject_q, 1);
        applyStimulus(1'b1, 100, 1'b1, 9, 9, 9);
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
        seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        checkOutput("busySeq.doneSeen", seen, 1);
        checkOutput("busySeq.remaining", bus.remaining, 0);
        checkOutput("busySeq.cntQ", bus.cnt_q, 3);
        checkOutput("busySeq.cntD", bus.cnt_d, 4);
        @(negedge clk);
        @(negedge clk);
        checkOutput("busySeq.stayIdle", bus.busy, 0);
        bus.coin_ack = 1'b0;

        // load_inv wins over a simultaneous start.
        @(negedge clk);
        applyStimulus(1'b1, 25, 1'b1, 7, 8, 9);
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
        checkOutput("loadStart.busy", bus.busy, 0);
        checkOutput("loadStart.cntQ", bus.cnt_q, 7);
        checkOutput("loadStart.cntD", bus.cnt_d, 8);
        checkOutput("loadStart.cntN", bus.cnt_n, 9);
        @(negedge clk);
        checkOutput("loadStart.stillIdle", bus.busy, 0);
        checkOutput("loadStart.noEject", bus.eject_q, 0);

        for (int i = 0; i < 25; i++) begin
            q  = int'($urandom_range(0, 8));
            d  = int'($urandom_range(0, 8));
            n  = int'($urandom_range(0, 8));
            ch = (i % 5 == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 150));
            refModel(q, d, n, ch, rCoins, rErr, rRem, rq, rd, rn);
            runTxn(q, d, n, ch, 1, rCoins, rErr, rRem, rq, rd, rn, -1, $sformatf("rnd%0d", i));
        end

        // Reset during a quarter pulse: ejects drop before any clock edge, no done follows.
        @(negedge clk);
        bus.coin_ack = 1'b1;
        applyStimulus(1'b0, 0, 1'b1, 5, 5, 5);
        @(negedge clk);
        applyStimulus(1'b1, 25, 1'b0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(1'b0, 0, 1'b0, 0, 0, 0);
        for (int t = 0; t < 20 && !bus.eject_q; t++) @(negedge clk);
        checkOutput("rstSeq.ejectQHigh", bus.eject_q, 1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rstSeq.ejectQAsync", bus.eject_q, 0);
        checkOutput("rstSeq.busy", bus.busy, 0);
        checkOutput("rstSeq.remaining", bus.remaining, 0);
        checkOutput("rstSeq.cntQ", bus.cnt_q, 0);
        checkOutput("rstSeq.cntD", bus.cnt_d, 0);
        checkOutput("rstSeq.err", bus.err, 0);
        doneCount = 0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (bus.done) doneCount++;
        end
        checkOutput("rstSeq.noDone", doneCount, 0);
        checkOutput("rstSeq.idleAfter", bus.busy, 0);
        bus.coin_ack = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
